// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 32-entry register file with write-through read ports,
// immediate sign extension, B-operand select and the registered ALU slot.
module operand_fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] SP_INIT = 32'h7FFF_EFFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InValid,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [ADDR_WIDTH-1:0] RegRs,
  input  logic [ADDR_WIDTH-1:0] RegRt,
  input  logic [15:0]           Immediate,
  input  logic                  ALUSrc,
  input  logic [3:0]            ALUOperationIn,
  input  logic                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  OutValid,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [3:0]            ALUOperation,
  output logic [DATA_WIDTH-1:0] RtData
);

  localparam int unsigned NREGS  = 2 ** ADDR_WIDTH;
  localparam int unsigned SP_REG = 29;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [DATA_WIDTH-1:0] sign_ext;
  logic [DATA_WIDTH-1:0] b_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_REG) ? SP_INIT : '0;
    end else if (WriteEnable && (WriteRegister != '0)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Same-cycle write-back is forwarded so the slot never captures stale data.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (RegRs != '0)
      rs_data = (WriteEnable && (WriteRegister == RegRs)) ? WriteData : regs[RegRs];
    if (RegRt != '0)
      rt_data = (WriteEnable && (WriteRegister == RegRt)) ? WriteData : regs[RegRt];
  end

  assign sign_ext = {{(DATA_WIDTH-16){Immediate[15]}}, Immediate};
  assign b_mux    = ALUSrc ? sign_ext : rt_data;

  always_ff @(posedge clk) begin
    if (reset || Flush || (!Stall && !InValid)) begin
      OutValid     <= 1'b0;
      A            <= '0;
      B            <= '0;
      ALUOperation <= '0;
      RtData       <= '0;
    end else if (!Stall) begin
      OutValid     <= 1'b1;
      A            <= rs_data;
      B            <= b_mux;
      ALUOperation <= ALUOperationIn;
      RtData       <= rt_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, InValid, Stall, Flush, ALUSrc, WriteEnable;
  logic [4:0]  RegRs, RegRt, WriteRegister;
  logic [15:0] Immediate;
  logic [3:0]  ALUOperationIn, ALUOperation;
  logic [31:0] WriteData, A, B, RtData;
  logic        OutValid;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .SP_INIT(32'h7FFF_EFFC)
  ) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .Stall(Stall), .Flush(Flush),
    .RegRs(RegRs), .RegRt(RegRt), .Immediate(Immediate), .ALUSrc(ALUSrc),
    .ALUOperationIn(ALUOperationIn), .WriteEnable(WriteEnable),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .OutValid(OutValid), .A(A), .B(B), .ALUOperation(ALUOperation), .RtData(RtData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; Stall = 1'b0; Flush = 1'b0; ALUSrc = 1'b0;
    WriteEnable = 1'b0; RegRs = '0; RegRt = '0; WriteRegister = '0;
    Immediate = '0; ALUOperationIn = '0; WriteData = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", {31'b0, OutValid}, 32'd0);
    check("rst_a", A, 32'd0);
    check("rst_b", B, 32'd0);
    check("rst_op", {28'b0, ALUOperation}, 32'd0);
    check("rst_rt", RtData, 32'd0);

    InValid = 1'b1; RegRs = 5'd29; RegRt = 5'd0;
    step();
    check("sp_a", A, 32'h7FFF_EFFC);
    check("sp_b", B, 32'd0);
    check("sp_valid", {31'b0, OutValid}, 32'd1);

    RegRs = 5'd5;
    step();
    check("r5_a", A, 32'd0);

    // r8 written, same-cycle bypass onto rs
    WriteEnable = 1'b1; WriteRegister = 5'd8; WriteData = 32'h0000_0010; RegRs = 5'd8;
    step();
    check("byp_r8_a", A, 32'h10);

    WriteRegister = 5'd9; WriteData = 32'hFFFF_FFF0; RegRt = 5'd9; ALUOperationIn = 4'd3;
    step();
    check("add_a", A, 32'h10);
    check("add_b", B, 32'hFFFF_FFF0);
    check("add_op", {28'b0, ALUOperation}, 32'd3);
    check("add_rt", RtData, 32'hFFFF_FFF0);

    WriteRegister = 5'd0; WriteData = 32'hDEAD_BEEF; RegRs = 5'd0; RegRt = 5'd0;
    step();
    check("r0_byp_a", A, 32'd0);
    check("r0_byp_b", B, 32'd0);

    WriteEnable = 1'b0; RegRs = 5'd0; RegRt = 5'd9;
    step();
    check("r0_read_a", A, 32'd0);
    check("r9_read_b", B, 32'hFFFF_FFF0);

    ALUSrc = 1'b1; Immediate = 16'h8001; RegRt = 5'd8;
    step();
    check("imm_neg_b", B, 32'hFFFF_8001);
    check("imm_neg_rt", RtData, 32'h10);

    Immediate = 16'h7FFF; ALUOperationIn = 4'hB;
    step();
    check("imm_pos_b", B, 32'h0000_7FFF);
    check("imm_pos_rt", RtData, 32'h10);
    check("op_undef", {28'b0, ALUOperation}, 32'hB);

    ALUSrc = 1'b0; ALUOperationIn = 4'd4;
    WriteEnable = 1'b1; WriteRegister = 5'd5; WriteData = 32'h5; RegRs = 5'd5; RegRt = 5'd8;
    step();
    check("load5_a", A, 32'h5);

    // stalled slot holds, write-back still lands in the array
    Stall = 1'b1; InValid = 1'b0;
    WriteRegister = 5'd11; WriteData = 32'h0000_CAFE;
    for (int i = 0; i < 3; i++) begin
      RegRs = (i == 0) ? 5'd8 : (i == 1) ? 5'd9 : 5'd29;
      step();
      WriteEnable = 1'b0;
      check("stall_a", A, 32'h5);
      check("stall_valid", {31'b0, OutValid}, 32'd1);
      check("stall_op", {28'b0, ALUOperation}, 32'd4);
    end

    Flush = 1'b1;
    step();
    check("flush_valid", {31'b0, OutValid}, 32'd0);
    check("flush_a", A, 32'd0);
    check("flush_b", B, 32'd0);
    check("flush_op", {28'b0, ALUOperation}, 32'd0);
    check("flush_rt", RtData, 32'd0);

    Flush = 1'b0; Stall = 1'b0; InValid = 1'b1; RegRs = 5'd11;
    step();
    check("stall_wb_a", A, 32'h0000_CAFE);
    check("stall_wb_valid", {31'b0, OutValid}, 32'd1);

    InValid = 1'b0;
    step();
    check("bubble_valid", {31'b0, OutValid}, 32'd0);
    check("bubble_a", A, 32'd0);

    InValid = 1'b1; RegRs = 5'd8;
    WriteEnable = 1'b1; WriteRegister = 5'd10; WriteData = 32'h77;
    step();
    WriteRegister = 5'd29; WriteData = 32'h99;
    step();
    check("pre_rst_valid", {31'b0, OutValid}, 32'd1);

    reset = 1'b1; WriteRegister = 5'd10; WriteData = 32'h1234;
    step();
    check("mid_rst_valid", {31'b0, OutValid}, 32'd0);
    check("mid_rst_a", A, 32'd0);
    check("mid_rst_b", B, 32'd0);
    check("mid_rst_rt", RtData, 32'd0);

    reset = 1'b0; WriteEnable = 1'b0; RegRs = 5'd10; RegRt = 5'd29; ALUSrc = 1'b0;
    step();
    check("r10_after_rst", A, 32'd0);
    check("r29_after_rst", B, 32'h7FFF_EFFC);

    RegRs = 5'd8; RegRt = 5'd11;
    step();
    check("r8_after_rst", A, 32'd0);
    check("r11_after_rst", B, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand stage that feeds the 32-bit ALU.
- Holds the 32x32 general-purpose register file (one write port, two read ports) and sign-extends the 16-bit immediate.
- Selects the ALU B operand and registers A, B, the 4-bit ALU operation code and the rt store data into an output pipeline register.
- Supports stall, flush and a valid bit per slot.

Parameters:
- DATA_WIDTH, 32, width of registers and operands.
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers).
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 (stack pointer).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- InValid  input  1  current decode slot holds a real instruction.
- Stall  input  1  hold output register contents.
- Flush  input  1  replace output slot with a bubble.
- RegRs  input  ADDR_WIDTH  source register for operand A.
- RegRt  input  ADDR_WIDTH  source register for operand B / store data.
- Immediate  input  16  instruction immediate field.
- ALUSrc  input  1  1: B = sign-extended immediate; 0: B = rt data.
- ALUOperationIn  input  4  operation code for the ALU (AND 0, OR 1, NOR 2, ADD 3, SUB 4).
- WriteEnable  input  1  write-back strobe.
- WriteRegister  input  ADDR_WIDTH  write-back destination.
- WriteData  input  DATA_WIDTH  write-back value.
- OutValid  output  1  registered valid bit for the ALU slot.
- A  output  DATA_WIDTH  registered ALU operand A.
- B  output  DATA_WIDTH  registered ALU operand B.
- ALUOperation  output  4  registered operation code to the ALU.
- RtData  output  DATA_WIDTH  registered rt value for stores.

Behaviour:
- Reset (synchronous, highest priority):
  - All registers clear to 0, except register 29, which loads SP_INIT.
  - OutValid, A, B, ALUOperation and RtData clear to 0.
  - A write-back presented in the reset cycle is discarded.
- Write port:
  - On a rising edge with WriteEnable=1, WriteRegister!=0 and reset=0, the register array stores WriteData.
  - Writes to register 0 are ignored; register 0 always reads 0.
- Read ports:
  - Combinational, with write-through bypass.
  - If WriteEnable=1, WriteRegister==RegRs and RegRs!=0, rsData = WriteData; otherwise rsData = array[RegRs]. The same rule applies to rtData.
  - Address 0 yields 0 regardless of the bypass.
- Immediate handling: SignExt = {16{Immediate[15]}, Immediate}. The B mux output is SignExt when ALUSrc=1, otherwise rtData.
- Output register update, priority reset > Flush > Stall > load:
  - Flush: OutValid<=0; A, B, ALUOperation, RtData <= 0. Flush overrides Stall in the same cycle.
  - Stall (Flush=0): all outputs hold.
  - Load with InValid=1: OutValid<=1, A<=rsData, B<=B-mux, ALUOperation<=ALUOperationIn, RtData<=rtData.
  - Load with InValid=0: bubble, with the same values as Flush.
- Write port independence: the register file write port works regardless of Stall and Flush. A stalled slot does not re-read the array. It keeps its captured operands; the upstream hazard unit owns resolving that.
- Latency: one cycle from inputs to registered outputs.
- ALUOperation codes are passed through unchanged, including undefined codes 5..15, which the ALU maps to result 0.
- No combinational path from any input to any output; all outputs come from flops.

Test Plan:
- Reset with SP_INIT default, then read:
  - RegRs=29, RegRt=0, ALUSrc=0, InValid=1 -> next cycle A=32'h7FFF_EFFC, B=0, OutValid=1.
  - RegRs=5 -> A=0.
- Write and bypass:
  - Write r8=32'h0000_0010. Then, with WriteEnable=1, WriteRegister=9, WriteData=32'hFFFF_FFF0 in the same cycle as RegRs=8, RegRt=9, ALUOperationIn=3 (ADD) -> A=32'h10, B=32'hFFFF_FFF0, ALUOperation=3.
- Register 0 protection:
  - Write r0=32'hDEAD_BEEF with RegRs=0 in the same cycle -> A=0.
  - A later read of r0 -> 0.
- Immediate sign extension:
  - ALUSrc=1, Immediate=16'h8001 -> B=32'hFFFF_8001.
  - Immediate=16'h7FFF -> B=32'h0000_7FFF.
  - In both cases RtData still equals r[RegRt].
- Stall and flush:
  - Load A=32'h5. Assert Stall for 3 cycles while changing RegRs -> A stays 32'h5, OutValid=1.
  - Assert Flush and Stall together -> OutValid=0, A=B=0, ALUOperation=0.
  - A write-back issued during the stall is visible on a later read.
- Reset mid-operation:
  - With OutValid=1 and a pending WriteEnable to r10, assert reset for one cycle -> all outputs 0, r10 reads 0, r29 reads SP_INIT.
